db9_pad_responder: RTL and testbench

//  Controller-side end of the Nitro-Core-DX DB9 pad link: emulates a 12-bit pad toward the console's
//  DB9 poller. Debounces 11 raw buttons, samples the console-driven select line and drives the

---
 rtl/db9_pad_responder_if.sv | 20 ++
 rtl/db9_pad_responder.sv | 164 ++++++++++++++++
 tb/tb_db9_pad_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/db9_pad_responder_if.sv
// DB9 pad link between the console-side poller and the pad emulator.
//   select_in : DB9 pin 7, driven by the host, asynchronous to the pad clock
//   db9_out   : DB9 pins 1..9 as bits 0..8, active low, driven by the pad
// Modports:
//   master : console / host side (drives select, reads data pins)
//   slave  : pad side (reads select, drives data pins)
interface db9_pad_responder_if;
  logic       select_in;
  logic [8:0] db9_out;

  modport master (
    output select_in,
    input  db9_out
  );

  modport slave (
    input  select_in,
    output db9_out
  );
endinterface

// File: rtl/db9_pad_responder.sv
// Controller-side end of the DB9 pad link: emulates a 12-bit pad toward the
// console's DB9 poller. Raw buttons are debounced, the host select line is
// synchronised, and every poll frame is served from one frozen snapshot.
// Ports:
//   clk          system clock (at least 2x the host poll clock)
//   reset        synchronous, active-high
//   buttons_raw  active-high raw buttons, console bit map (bit 11 ignored)
//   db9          DB9 link (slave modport): select_in in, db9_out out
//   buttons_db   debounced buttons, bit 11 always 0
//   host_active  high while a poll frame is open
//   poll_count   number of frames opened, wraps
// Bit map: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 A, 5 B, 6 C, 7 L, 8 R,
//          9 SELECT, 10 START.
module db9_pad_responder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd2000,
  parameter logic [15:0] IDLE_TIMEOUT    = 16'd5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        buttons_raw,
  db9_pad_responder_if.slave db9,
  output logic [11:0]        buttons_db,
  output logic               host_active,
  output logic [15:0]        poll_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  state_t      state_r;
  logic        sync1_r;
  logic        sel_r;
  logic        sel_d_r;
  logic        fall_s;
  logic [10:0] db_r;
  logic [10:0] db_nxt_s;
  logic [15:0] cnt_r     [11];
  logic [15:0] cnt_nxt_s [11];
  logic [10:0] snap_r;
  logic [15:0] idle_cnt_r;
  logic        unused_raw_s;

  assign unused_raw_s = buttons_raw[11];
  assign fall_s       = ~sel_r & sel_d_r;
  assign buttons_db   = {1'b0, db_r};

  // Maps the snapshot onto the active-low pins for the current select phase.
  // Bits 4, 6 and 7 (+5V, select, GND) are never pulled low.
  function automatic logic [8:0] pins_f(input logic hi, input logic [10:0] s);
    logic [8:0] p;
    p = 9'h1FF;
    if (hi) begin
      p[3:0] = ~{s[9], s[10], s[8], s[7]};
      p[5]   = ~s[4];
      p[8]   = ~s[6];
    end else begin
      p[3:0] = ~s[3:0];
      p[5]   = ~s[4];
      p[8]   = ~s[5];
    end
    return p;
  endfunction

  // Two-flop synchroniser for the host select plus a delay stage for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sel_r   <= 1'b1;
      sel_d_r <= 1'b1;
    end else begin
      sync1_r <= db9.select_in;
      sel_r   <= sync1_r;
      sel_d_r <= sel_r;
    end
  end

  // Next-state debounce per button; the counter only runs while raw disagrees.
  always_comb begin
    for (int i = 0; i < 11; i++) begin
      db_nxt_s[i]  = db_r[i];
      cnt_nxt_s[i] = 16'd0;
      if (buttons_raw[i] == db_r[i]) begin
        cnt_nxt_s[i] = 16'd0;
      end else if (DEBOUNCE_CYCLES == 16'd0) begin
        db_nxt_s[i] = buttons_raw[i];
      end else if (cnt_r[i] == DEBOUNCE_CYCLES - 16'd1) begin
        db_nxt_s[i] = buttons_raw[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 16'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r <= 11'd0;
      for (int i = 0; i < 11; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else begin
      db_r <= db_nxt_s;
      for (int i = 0; i < 11; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Frame FSM, snapshot capture and registered pin drive.
  // The snapshot takes db_nxt_s so an acceptance on the fall edge is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      host_active <= 1'b0;
      poll_count  <= 16'd0;
      snap_r      <= 11'd0;
      idle_cnt_r  <= 16'd0;
      db9.db9_out <= 9'h1FF;
    end else begin
      db9.db9_out <= pins_f(sel_r, snap_r);
      case (state_r)
        ST_IDLE: begin
          snap_r <= db_nxt_s;
          if (fall_s) begin
            state_r     <= ST_LO;
            host_active <= 1'b1;
            poll_count  <= poll_count + 16'd1;
          end else begin
            host_active <= 1'b0;
          end
        end
        ST_LO: begin
          if (sel_r) begin
            state_r    <= ST_HI;
            idle_cnt_r <= 16'd0;
          end else begin
            state_r <= ST_LO;
          end
        end
        ST_HI: begin
          // A new frame beats the timeout when both land on the same cycle.
          if (fall_s) begin
            state_r    <= ST_LO;
            poll_count <= poll_count + 16'd1;
            snap_r     <= db_nxt_s;
          end else if (idle_cnt_r == IDLE_TIMEOUT) begin
            state_r     <= ST_IDLE;
            host_active <= 1'b0;
          end else begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          host_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db9_pad_responder.sv
module tb_db9_pad_responder;
  localparam logic [15:0] DEB = 16'd20;
  localparam logic [15:0] IDL = 16'd40;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] buttons_raw;
  logic [11:0] buttons_db;
  logic        host_active;
  logic [15:0] poll_count;

  db9_pad_responder_if db9_bus ();

  db9_pad_responder #(.DEBOUNCE_CYCLES(DEB), .IDLE_TIMEOUT(IDL)) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons_raw (buttons_raw),
    .db9         (db9_bus.slave),
    .buttons_db  (buttons_db),
    .host_active (host_active),
    .poll_count  (poll_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the pad should look like after each edge.
  bit        m_sync1, m_sel, m_seld;
  bit [10:0] m_db;
  int        m_age [11];
  bit        m_open, m_high;
  int        m_hi_cycles;
  bit [10:0] m_snap;
  bit [8:0]  m_pins;
  bit [15:0] m_polls;

  // Which button drives each of pins 0..3, 5 and 8, per select phase.
  int lo_src [6] = '{0, 1, 2, 3, 4, 5};
  int hi_src [6] = '{7, 8, 10, 9, 4, 6};
  int pin_idx [6] = '{0, 1, 2, 3, 5, 8};

  function automatic bit [8:0] expect_pins(bit hi, bit [10:0] s);
    bit [8:0] p;
    p = 9'h1FF;
    for (int k = 0; k < 6; k++) begin
      if (hi) p[pin_idx[k]] = !s[hi_src[k]];
      else    p[pin_idx[k]] = !s[lo_src[k]];
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit        fall;
    bit [10:0] nd;
    bit [8:0]  np;
    if (reset) begin
      m_sync1 = 1'b1; m_sel = 1'b1; m_seld = 1'b1;
      m_db = 11'd0;
      for (int i = 0; i < 11; i++) m_age[i] = 0;
      m_open = 1'b0; m_high = 1'b0; m_hi_cycles = 0;
      m_snap = 11'd0; m_pins = 9'h1FF; m_polls = 16'd0;
      return;
    end
    fall = !m_sel && m_seld;
    nd = m_db;
    for (int i = 0; i < 11; i++) begin
      if (buttons_raw[i] == m_db[i]) m_age[i] = 0;
      else if (DEB == 16'd0) nd[i] = buttons_raw[i];
      else if (m_age[i] + 1 >= int'(DEB)) begin nd[i] = buttons_raw[i]; m_age[i] = 0; end
      else m_age[i] = m_age[i] + 1;
    end
    np = expect_pins(m_sel, m_snap);
    if (!m_open) begin
      m_snap = nd;
      if (fall) begin m_open = 1'b1; m_high = 1'b0; m_polls = m_polls + 16'd1; end
    end else if (!m_high) begin
      if (m_sel) begin m_high = 1'b1; m_hi_cycles = 0; end
    end else begin
      if (fall) begin m_high = 1'b0; m_polls = m_polls + 16'd1; m_snap = nd; end
      else if (m_hi_cycles == int'(IDL)) begin m_open = 1'b0; m_high = 1'b0; end
      else m_hi_cycles = m_hi_cycles + 1;
    end
    m_seld = m_sel; m_sel = m_sync1; m_sync1 = db9_bus.select_in;
    m_db = nd; m_pins = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pins",   {7'd0, db9_bus.db9_out}, {7'd0, m_pins});
    check("db",     {4'd0, buttons_db},      {5'd0, m_db});
    check("active", {15'd0, host_active},    {15'd0, m_open});
    check("polls",  poll_count,              m_polls);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int len;
    reset = 1'b1; buttons_raw = 12'h7FF; db9_bus.select_in = 1'b1;

    // T1 reset
    ticks(5);
    check("t1_pins", {7'd0, db9_bus.db9_out}, 16'h01FF);
    check("t1_db", buttons_db, 16'h0000);
    check("t1_polls", poll_count, 16'h0000);

    // T2 LO phase with UP+A+B
    reset = 1'b0; buttons_raw = 12'h031;
    ticks(int'(DEB) + 5);
    db9_bus.select_in = 1'b0;
    ticks(3);
    check("t2_pins", {7'd0, db9_bus.db9_out}, 16'h00DE);
    check("t2_polls", poll_count, 16'h0001);

    // T3 HI phase with START+C after the previous frame closes
    buttons_raw = 12'h440; db9_bus.select_in = 1'b1;
    ticks(int'(IDL) + int'(DEB) + 10);
    check("t3_idle", {15'd0, host_active}, 16'h0000);
    db9_bus.select_in = 1'b0; ticks(5);
    db9_bus.select_in = 1'b1; ticks(5);
    check("t3_pins", {7'd0, db9_bus.db9_out}, 16'h00FB);

    // T4 L pressed mid-frame is not visible until the next frame
    db9_bus.select_in = 1'b0; ticks(5);
    buttons_raw = 12'h4C0; ticks(int'(DEB) + 5);
    db9_bus.select_in = 1'b1; ticks(5);
    check("t4_frozen", {7'd0, db9_bus.db9_out}, 16'h00FB);
    ticks(int'(IDL) + 10);
    db9_bus.select_in = 1'b0; ticks(5);
    db9_bus.select_in = 1'b1; ticks(5);
    check("t4_live", {7'd0, db9_bus.db9_out}, 16'h00FA);

    // T5 debounce rejects short toggles on A
    buttons_raw = 12'h000; ticks(int'(DEB) + 5);
    for (int k = 0; k < 6; k++) begin
      buttons_raw[4] = ~buttons_raw[4];
      ticks(int'(DEB) / 2);
      check("t5_bounce", {15'd0, buttons_db[4]}, 16'h0000);
    end
    buttons_raw = 12'h010; ticks(int'(DEB) + 2);
    check("t5_accept", buttons_db, 16'h0010);

    // T6 reset in the middle of a LO phase
    buttons_raw = 12'h7FF; ticks(int'(DEB) + 2);
    db9_bus.select_in = 1'b0; ticks(5);
    check("t6_open", {15'd0, host_active}, 16'h0001);
    reset = 1'b1; tick();
    check("t6_pins", {7'd0, db9_bus.db9_out}, 16'h01FF);
    check("t6_active", {15'd0, host_active}, 16'h0000);
    check("t6_polls", poll_count, 16'h0000);
    reset = 1'b0;

    // Random select timing and button activity against the model
    for (int n = 0; n < 120; n++) begin
      db9_bus.select_in = ~db9_bus.select_in;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                        : int'($urandom_range(3, int'(IDL) + 15));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 25) == 0) buttons_raw = 12'($urandom);
        if ($urandom_range(0, 40) == 0) buttons_raw[$urandom_range(0, 10)] ^= 1'b1;
        reset = ($urandom_range(0, 1500) == 0);
        tick();
      end
    end
    reset = 1'b0;
    ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
